// File: rtl/alu_adder_arbiter_if.sv
// Request/response bundle for the shared ALU adder: NREQ packed requesters in, one result channel out.
// master = requesters plus result consumer, slave = the arbiter/adder block.
interface alu_adder_arbiter_if #(
   parameter int N    = 8,
   parameter int NREQ = 4
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*N-1:0] req_a;
   logic [NREQ*N-1:0] req_b;
   logic [NREQ-1:0]   req_sub;
   logic [NREQ-1:0]   req_sat;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [N-1:0]      rsp_sum;
   logic              rsp_cout;
   logic              rsp_clip;

   modport master (
      output req_valid, req_a, req_b, req_sub, req_sat, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_clip
   );

   modport slave (
      input  req_valid, req_a, req_b, req_sub, req_sat, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_clip
   );
endinterface

// File: rtl/alu_adder_arbiter.sv
// Round-robin share of one Kogge-Stone adder (add/sub, optional unsigned saturation); accept at edge T -> rsp_valid after T+1.
// Two-stage operand/result pipeline; req_ready falls only when both stages are full and rsp_ready is low.
module alu_adder_arbiter #(
   parameter int N    = 8,
   parameter int NREQ = 4
) (
   input logic            clk,
   input logic            rst,
   alu_adder_arbiter_if.slave bus
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic           sub;
      logic           sat;
      logic [N-1:0]   b;
      logic [N-1:0]   a;
   } op_t;

   op_t            op;
   op_t            next_op;
   logic           op_valid;
   logic [IDW-1:0] ptr;

   logic           res_valid;
   logic [IDW-1:0] res_id;
   logic [N-1:0]   res_sum;
   logic           res_cout;
   logic           res_clip;

   logic           adv1;
   logic           adv2;
   logic           accept;
   logic [NREQ-1:0] grant;
   logic [IDW-1:0] gnt_id;
   logic [IDW-1:0] sel;
   int             idx;

   assign adv2 = !res_valid || bus.rsp_ready;
   assign adv1 = !op_valid || adv2;

   // Scan from ptr+NREQ-1 down to ptr so the last hit is the one closest to ptr.
   always_comb begin
      grant   = '0;
      gnt_id  = '0;
      sel     = '0;
      idx     = 0;
      next_op = '0;
      for (int j = NREQ - 1; j >= 0; j--) begin
         idx = (int'(ptr) + j) % NREQ;
         sel = IDW'(idx);
         if (bus.req_valid[sel]) begin
            grant      = '0;
            grant[sel] = 1'b1;
            gnt_id     = sel;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            next_op.a   = bus.req_a[i*N +: N];
            next_op.b   = bus.req_b[i*N +: N];
            next_op.sub = bus.req_sub[i];
            next_op.sat = bus.req_sat[i];
         end
      end
      next_op.id = gnt_id;
   end

   assign bus.req_ready = (rst || !adv1) ? '0 : grant;
   assign accept        = |(bus.req_valid & bus.req_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_valid <= 1'b0;
         op       <= '0;
         ptr      <= '0;
      end else if (adv1) begin
         op_valid <= accept;
         if (accept) begin
            op  <= next_op;
            ptr <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
         end
      end
   end

   logic [N-1:0] add_b;
   logic [N-1:0] gen;
   logic [N-1:0] prop;
   logic [N-1:0] gen_prev;
   logic [N-1:0] prop_prev;
   logic [N-1:0] sum_raw;
   logic [N-1:0] sum_sat;
   logic         cout_raw;
   logic         clip;

   // Carry-in folded into bit 0 generate, so gen[i] is the carry out of bit i.
   always_comb begin
      add_b     = op.sub ? ~op.b : op.b;
      gen       = op.a & add_b;
      prop      = op.a ^ add_b;
      gen[0]    = gen[0] | (prop[0] & op.sub);
      gen_prev  = '0;
      prop_prev = '0;
      for (int d = 1; d < N; d = d * 2) begin
         gen_prev  = gen;
         prop_prev = prop;
         for (int i = d; i < N; i++) begin
            gen[i]  = gen_prev[i] | (prop_prev[i] & gen_prev[i-d]);
            prop[i] = prop_prev[i] & prop_prev[i-d];
         end
      end
      sum_raw  = (op.a ^ add_b) ^ {gen[N-2:0], op.sub};
      cout_raw = gen[N-1];
      sum_sat  = sum_raw;
      clip     = 1'b0;
      if (op.sat && (op.sub ? !cout_raw : cout_raw)) begin
         clip    = 1'b1;
         sum_sat = op.sub ? '0 : '1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid <= 1'b0;
         res_id    <= '0;
         res_sum   <= '0;
         res_cout  <= 1'b0;
         res_clip  <= 1'b0;
      end else if (adv2) begin
         res_valid <= op_valid;
         if (op_valid) begin
            res_id   <= op.id;
            res_sum  <= sum_sat;
            res_cout <= cout_raw;
            res_clip <= clip;
         end
      end
   end

   assign bus.rsp_valid = res_valid;
   assign bus.rsp_id    = res_id;
   assign bus.rsp_sum   = res_sum;
   assign bus.rsp_cout  = res_cout;
   assign bus.rsp_clip  = res_clip;
endmodule

// File: tb/tb_alu_adder_arbiter.sv
// Directed vectors on an N=8 instance plus a scoreboarded random soak driving N=8 and N=16 instances in lockstep.
module tb_alu_adder_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   alu_adder_arbiter_if #(.N(8),  .NREQ(4)) b8 ();
   alu_adder_arbiter_if #(.N(16), .NREQ(4)) b16 ();

   alu_adder_arbiter #(.N(8),  .NREQ(4)) dut8  (.clk(clk), .rst(rst), .bus(b8));
   alu_adder_arbiter #(.N(16), .NREQ(4)) dut16 (.clk(clk), .rst(rst), .bus(b16));

   logic [3:0]  exp_rdy;
   logic [3:0]  pending;
   logic [15:0] sa [4];
   logic [15:0] sb [4];
   logic        ssub [4];
   logic        ssat [4];
   logic        rr;
   logic [63:0] q8 [$];
   logic [63:0] q16 [$];
   logic [63:0] obs;
   int          got;
   int          cyc;

   task automatic chk(input string tag, input logic [63:0] seen, input logic [63:0] want);
      n_checks++;
      if (seen !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, seen, want);
      end
   endtask

   task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [7:0] s,
                          input logic c, input logic l);
      chk({tag, "_vld"},  64'(b8.rsp_valid), 64'(1'b1));
      chk({tag, "_id"},   64'(b8.rsp_id),    64'(id));
      chk({tag, "_sum"},  64'(b8.rsp_sum),   64'(s));
      chk({tag, "_cout"}, 64'(b8.rsp_cout),  64'(c));
      chk({tag, "_clip"}, 64'(b8.rsp_clip),  64'(l));
   endtask

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic sub, input logic sat);
      b8.req_valid[i]     = 1'b1;
      b8.req_a[i*8 +: 8]  = a;
      b8.req_b[i*8 +: 8]  = b;
      b8.req_sub[i]       = sub;
      b8.req_sat[i]       = sat;
   endtask

   task automatic one_op(input string tag, input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic sub, input logic sat,
                         input logic [7:0] es, input logic ec, input logic el);
      logic [3:0] want_rdy;
      want_rdy = 4'b0001 << i;
      @(negedge clk);
      set_req(i, a, b, sub, sat);
      #1;
      chk({tag, "_rdy"}, 64'(b8.req_ready), 64'(want_rdy));
      @(negedge clk);
      b8.req_valid = '0;
      chk({tag, "_lat"}, 64'(b8.rsp_valid), 64'(1'b0));
      @(negedge clk);
      chk_rsp(tag, 2'(i), es, ec, el);
   endtask

   function automatic logic [63:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                         input logic sub, input logic sat, input logic [1:0] id);
      logic [31:0] mask;
      logic [31:0] s;
      logic [32:0] r;
      logic        cout;
      logic        clip;
      mask = (w == 8) ? 32'h0000_00FF : 32'h0000_FFFF;
      r    = '0;
      if (sub) begin
         cout = (({16'b0, a} & mask) >= ({16'b0, b} & mask));
         s    = ({16'b0, a} - {16'b0, b}) & mask;
      end else begin
         r    = {17'b0, a & mask[15:0]} + {17'b0, b & mask[15:0]};
         cout = (w == 8) ? r[8] : r[16];
         s    = r[31:0] & mask;
      end
      clip = 1'b0;
      if (sat && !sub && cout) begin
         s    = mask;
         clip = 1'b1;
      end else if (sat && sub && !cout) begin
         s    = '0;
         clip = 1'b1;
      end
      return {26'b0, 2'b0, id, clip, cout, s};
   endfunction

   initial begin
      b8.req_valid  = '0; b8.req_a  = '0; b8.req_b  = '0; b8.req_sub  = '0; b8.req_sat  = '0;
      b16.req_valid = '0; b16.req_a = '0; b16.req_b = '0; b16.req_sub = '0; b16.req_sat = '0;
      b8.rsp_ready  = 1'b1;
      b16.rsp_ready = 1'b1;

      // Reset values, and req_ready held low while rst is high.
      #1 rst = 1'b1;
      #2;
      chk("rst_vld",  64'(b8.rsp_valid), 64'(1'b0));
      chk("rst_id",   64'(b8.rsp_id),    64'(2'd0));
      chk("rst_sum",  64'(b8.rsp_sum),   64'(8'd0));
      chk("rst_cout", 64'(b8.rsp_cout),  64'(1'b0));
      chk("rst_clip", 64'(b8.rsp_clip),  64'(1'b0));
      set_req(0, 8'h01, 8'h01, 1'b0, 1'b0);
      #1;
      chk("rst_rdy", 64'(b8.req_ready), 64'(4'b0000));
      b8.req_valid = '0;
      @(negedge clk);
      rst = 1'b0;

      one_op("add",       2, 8'h64, 8'h32, 1'b0, 1'b0, 8'h96, 1'b0, 1'b0);
      one_op("add_wrap",  0, 8'hF0, 8'h20, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0);
      one_op("add_sat",   1, 8'hF0, 8'h20, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
      one_op("sub_wrap",  2, 8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0);
      one_op("sub_sat",   3, 8'h10, 8'h20, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
      one_op("sub_pos",   0, 8'h20, 8'h10, 1'b1, 1'b0, 8'h10, 1'b1, 1'b0);
      one_op("add_ff01",  1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      one_op("sub_equal", 3, 8'h55, 8'h55, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);

      // Round robin: ptr is back at 0 after the requester-3 op above.
      @(negedge clk);
      for (int i = 0; i < 4; i++) set_req(i, 8'(16 * i + 1), 8'h01, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         if (k == 8) b8.req_valid = '0;
         if (k >= 2) begin
            chk("rr_vld", 64'(b8.rsp_valid), 64'(1'b1));
            chk("rr_id",  64'(b8.rsp_id),    64'((k - 2) % 4));
            chk("rr_sum", 64'(b8.rsp_sum),   64'(8'(16 * ((k - 2) % 4) + 2)));
         end
         if (k < 8) begin
            #1;
            exp_rdy = 4'b0001 << (k % 4);
            chk("rr_rdy", 64'(b8.req_ready), 64'(exp_rdy));
         end
         @(negedge clk);
      end

      // Backpressure: fill both stages, stall, release a single response.
      b8.rsp_ready = 1'b0;
      set_req(0, 8'h01, 8'h02, 1'b0, 1'b0);
      set_req(1, 8'h03, 8'h04, 1'b0, 1'b0);
      #1;
      chk("bp_rdy0", 64'(b8.req_ready), 64'(4'b0001));
      @(negedge clk);
      set_req(0, 8'h05, 8'h06, 1'b0, 1'b0);
      #1;
      chk("bp_rdy1", 64'(b8.req_ready), 64'(4'b0010));
      @(negedge clk);
      b8.req_valid[1] = 1'b0;
      #1;
      chk("bp_full_rdy", 64'(b8.req_ready), 64'(4'b0000));
      chk_rsp("bp_first", 2'd0, 8'h03, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_stall_rdy", 64'(b8.req_ready), 64'(4'b0000));
         chk_rsp("bp_stall", 2'd0, 8'h03, 1'b0, 1'b0);
      end
      b8.rsp_ready = 1'b1;
      #1;
      chk("bp_pass_rdy", 64'(b8.req_ready), 64'(4'b0001));
      @(negedge clk);
      b8.rsp_ready = 1'b0;
      b8.req_valid = '0;
      chk_rsp("bp_second", 2'd1, 8'h07, 1'b0, 1'b0);
      @(negedge clk);
      chk_rsp("bp_second_hold", 2'd1, 8'h07, 1'b0, 1'b0);

      // Reset with both stages full: outputs clear without a clock edge.
      set_req(2, 8'h11, 8'h22, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      chk("mid_rst_vld", 64'(b8.rsp_valid), 64'(1'b0));
      chk("mid_rst_rdy", 64'(b8.req_ready), 64'(4'b0000));
      chk("mid_rst_sum", 64'(b8.rsp_sum),   64'(8'h00));
      @(negedge clk);
      b8.req_valid = '0;
      b8.rsp_ready = 1'b1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("post_rst_idle", 64'(b8.rsp_valid), 64'(1'b0));
      end
      one_op("post_rst", 1, 8'h40, 8'h02, 1'b1, 1'b0, 8'h3E, 1'b1, 1'b0);

      // Soak: identical control on both widths, each checked against its own scoreboard.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      pending = '0;
      got = 0;
      cyc = 0;
      while (got < 2000 && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < 4; i++) begin
            if (pending[i] && $urandom_range(0, 15) == 0) begin
               pending[i] = 1'b0;
            end else if (!pending[i] && $urandom_range(0, 3) != 0) begin
               sa[i]      = 16'($urandom);
               sb[i]      = 16'($urandom);
               ssub[i]    = 1'($urandom);
               ssat[i]    = 1'($urandom);
               pending[i] = 1'b1;
            end
            b8.req_a[i*8 +: 8]    = sa[i][7:0];
            b8.req_b[i*8 +: 8]    = sb[i][7:0];
            b16.req_a[i*16 +: 16] = sa[i];
            b16.req_b[i*16 +: 16] = sb[i];
            b8.req_sub[i]  = ssub[i];
            b8.req_sat[i]  = ssat[i];
            b16.req_sub[i] = ssub[i];
            b16.req_sat[i] = ssat[i];
         end
         b8.req_valid  = pending;
         b16.req_valid = pending;
         rr = ($urandom_range(0, 3) != 0);
         b8.rsp_ready  = rr;
         b16.rsp_ready = rr;
         #1;
         if (b8.rsp_valid && rr) begin
            obs = {26'b0, 2'b0, b8.rsp_id, b8.rsp_clip, b8.rsp_cout, 24'b0, b8.rsp_sum};
            if (q8.size() == 0) chk("sb8_unexpected", obs, 64'(0));
            else chk("sb8", obs, q8.pop_front());
            got++;
         end
         if (b16.rsp_valid && rr) begin
            obs = {26'b0, 2'b0, b16.rsp_id, b16.rsp_clip, b16.rsp_cout, 16'b0, b16.rsp_sum};
            if (q16.size() == 0) chk("sb16_unexpected", obs, 64'(0));
            else chk("sb16", obs, q16.pop_front());
         end
         for (int i = 0; i < 4; i++) begin
            if (b8.req_valid[i] && b8.req_ready[i]) begin
               q8.push_back(model(8, sa[i], sb[i], ssub[i], ssat[i], 2'(i)));
               pending[i] = 1'b0;
            end
            if (b16.req_valid[i] && b16.req_ready[i])
               q16.push_back(model(16, sa[i], sb[i], ssub[i], ssat[i], 2'(i)));
         end
      end
      if (got < 2000) chk("soak_timeout", 64'(got), 64'(2000));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
